// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared FSM state encoding, LSU access-type codes and read-latency limit.
package lsu_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam int RD_LATENCY_MAX = 3;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; LSU_ARB_FIXED_PRIO_EN makes port 0 win every tie.
module rr_arbiter_2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
`ifdef LSU_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused  = ^{i_clk, i_reset, i_accept};
  assign o_grant = i_valid[0] ? 2'b01 : {i_valid[1], 1'b0};
`else
  logic ptr_q, ptr_d;
  // ptr_q remembers the last granted port; it starts at 1 so port 0 wins the first tie
  always_comb ptr_d = i_accept ? o_grant[1] : ptr_q;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) ptr_q <= 1'b1;
    else          ptr_q <= ptr_d;
  assign o_grant = &i_valid ? (ptr_q ? 2'b01 : 2'b10) : i_valid;
`endif
endmodule

// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter: shares one LSU port between two valid/ready requesters, one transaction in flight.
// Define LSU_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module lsu_port_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_wdata,
  input  logic              i_req0_wren,
  input  logic [2:0]        i_req0_type,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_rdata,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_wdata,
  input  logic              i_req1_wren,
  input  logic [2:0]        i_req1_type,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_rdata,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_lsu_st_data,
  output logic              o_lsu_wren,
  output logic [2:0]        o_lsu_type_access,
  input  logic [DATA_W-1:0] i_lsu_ld_data
);
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY > 0 ? RD_LATENCY - 1 : 0);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wren_q, wren_d;
  logic              owner_q, owner_d;
  logic [1:0]        grant;
  logic              idle, accept, sample;
  assign idle   = state_q == IDLE;
  assign accept = idle && |grant;
  // load data is captured on the cycle it becomes valid: ISSUE itself or the last WAIT cycle
  assign sample = (state_q == ISSUE && RD_LATENCY == 0) || (state_q == WAIT && cnt_q == 2'd0);
  rr_arbiter_2 u_arb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  ({i_req1_valid, i_req0_valid}),
    .i_accept (accept),
    .o_grant  (grant)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = RD_LATENCY == 0 ? RESP : WAIT;
      WAIT:    state_d = cnt_q == 2'd0 ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
    owner_d = accept ? grant[1] : owner_q;
    addr_d  = accept ? (grant[1] ? i_req1_addr  : i_req0_addr)  : addr_q;
    wdata_d = accept ? (grant[1] ? i_req1_wdata : i_req0_wdata) : wdata_q;
    wren_d  = accept ? (grant[1] ? i_req1_wren  : i_req0_wren)  : wren_q;
    type_d  = accept ? (grant[1] ? i_req1_type  : i_req0_type)  : type_q;
    cnt_d   = state_q == WAIT ? cnt_q - 2'd1 : CNT_INIT;
    rdata_d = sample ? (wren_q ? '0 : i_lsu_ld_data) : rdata_q;
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      type_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  assign o_req0_ready      = i_reset && idle && grant[0];
  assign o_req1_ready      = i_reset && idle && grant[1];
  assign o_lsu_addr        = addr_q;
  assign o_lsu_st_data     = wdata_q;
  assign o_lsu_type_access = type_q;
  assign o_lsu_wren        = state_q == ISSUE && wren_q;
  assign o_rsp0_valid      = state_q == RESP && !owner_q;
  assign o_rsp1_valid      = state_q == RESP && owner_q;
  assign o_rsp0_rdata      = o_rsp0_valid ? rdata_q : '0;
  assign o_rsp1_rdata      = o_rsp1_valid ? rdata_q : '0;
endmodule
